// File: rtl/video_mix_pkg.sv
// Shared types and helpers for the layered video mixer: palette entry layout,
// reset palette value and the saturating component adder.
package video_mix_pkg;

  localparam int MAX_COMP_W = 8;
  localparam int SUM_MAX_W  = 16;

  typedef struct packed {
    logic [MAX_COMP_W-1:0] r;
    logic [MAX_COMP_W-1:0] g;
    logic [MAX_COMP_W-1:0] b;
  } pal_entry_t;

  // Mid-grey at the widest component size; narrower cores shift it down.
  localparam pal_entry_t PAL_DEFAULT = '{r: 8'h7F, g: 8'h7F, b: 8'h7F};

  function automatic logic [SUM_MAX_W-1:0] sat_add(
    input logic [SUM_MAX_W-1:0] a,
    input logic [SUM_MAX_W-1:0] b,
    input int                   comp_w
  );
    logic [SUM_MAX_W-1:0] max_v;
    logic [SUM_MAX_W-1:0] sum;
    max_v = SUM_MAX_W'((1 << comp_w) - 1);
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/vmix_frame_ctl.sv
// Frame-rate control for the mixer: vsync edge detect, inversion request
// accumulator with per-frame latch, and the blink frame counter / phase.
module vmix_frame_ctl #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce_pix,
  input  logic vsync_in,
  input  logic inv_in,
  output logic frame_inv,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             vsync_prev;
  logic             cur_inv;
  logic [CNT_W-1:0] blink_cnt;
  logic             vs_rise;

  // The edge is judged only on pixel beats, so a vsync pulse confined to
  // stalled cycles is never seen.
  assign vs_rise = ce_pix & vsync_in & ~vsync_prev;

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev  <= 1'b0;
      cur_inv     <= 1'b0;
      frame_inv   <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (ce_pix) begin
      vsync_prev <= vsync_in;
      if (vs_rise) begin
        frame_inv <= cur_inv | inv_in;
        cur_inv   <= 1'b0;
        if (blink_cnt == CNT_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        cur_inv <= cur_inv | inv_in;
      end
    end
  end

endmodule

// File: rtl/video_layer_mixer.sv
// Mixes NUM_LAYERS 1-bit video layers through a two-bank RGB weight palette
// into saturated, blink/invert-aware COMP_W-bit colour with matched timing.
module video_layer_mixer
  import video_mix_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COMP_W       = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic                          ce_pix,
  input  logic                          color_mode,
  input  logic [NUM_LAYERS-1:0]         layers_in,
  input  logic                          inv_in,
  input  logic [NUM_LAYERS-1:0]         blink_en,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          hblank_in,
  input  logic                          vblank_in,
  input  logic                          pal_we,
  input  logic [$clog2(NUM_LAYERS):0]   pal_addr,
  input  logic [3*COMP_W-1:0]           pal_data,
  output logic [COMP_W-1:0]             r_out,
  output logic [COMP_W-1:0]             g_out,
  output logic [COMP_W-1:0]             b_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          hblank_out,
  output logic                          vblank_out,
  output logic                          frame_inv
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int PW = 3 * COMP_W;
  localparam logic [COMP_W-1:0] PAL_H = COMP_W'(PAL_DEFAULT.r >> (MAX_COMP_W - COMP_W));

  logic [PW-1:0] pal [2][NUM_LAYERS];
  logic          wr_bank;
  logic [LW-1:0] wr_layer;
  logic          blink_phase;

  assign wr_bank  = pal_addr[LW];
  assign wr_layer = pal_addr[LW-1:0];

  // NOTE: the palette is a handful of flops rather than a RAM macro, so it can
  // legitimately be reset to its default contents.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_LAYERS; i++)
          pal[b][i] <= {PAL_H, PAL_H, PAL_H};
    end else if (pal_we && (int'(wr_layer) < NUM_LAYERS)) begin
      pal[wr_bank][wr_layer] <= pal_data;
    end
  end

  vmix_frame_ctl #(.BLINK_FRAMES(BLINK_FRAMES)) u_frame_ctl (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .vsync_in    (vsync_in),
    .inv_in      (inv_in),
    .frame_inv   (frame_inv),
    .blink_phase (blink_phase)
  );

  // Stage 1: blink-masked per-layer weight lookup.
  logic [PW-1:0] w_next [NUM_LAYERS];
  logic [PW-1:0] s1_w   [NUM_LAYERS];
  logic          s1_hs, s1_vs, s1_hb, s1_vb;

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_next[i] = (layers_in[i] & ~(blink_en[i] & blink_phase)) ? pal[color_mode][i] : '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) s1_w[i] <= '0;
      {s1_hs, s1_vs, s1_hb, s1_vb} <= '0;
    end else if (ce_pix) begin
      for (int i = 0; i < NUM_LAYERS; i++) s1_w[i] <= w_next[i];
      {s1_hs, s1_vs, s1_hb, s1_vb} <= {hsync_in, vsync_in, hblank_in, vblank_in};
    end
  end

  // Stage 2: clamped accumulation equals clamping the full-width sum, since
  // every weight is non-negative.
  logic [COMP_W-1:0] acc_r, acc_g, acc_b;
  logic [COMP_W-1:0] mix_r, mix_g, mix_b;

  always_comb begin
    acc_r = '0;
    acc_g = '0;
    acc_b = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      acc_r = COMP_W'(sat_add(SUM_MAX_W'(acc_r), SUM_MAX_W'(s1_w[i][PW-1 -: COMP_W]), COMP_W));
      acc_g = COMP_W'(sat_add(SUM_MAX_W'(acc_g), SUM_MAX_W'(s1_w[i][2*COMP_W-1 -: COMP_W]), COMP_W));
      acc_b = COMP_W'(sat_add(SUM_MAX_W'(acc_b), SUM_MAX_W'(s1_w[i][COMP_W-1:0]), COMP_W));
    end
    mix_r = acc_r ^ {COMP_W{frame_inv}};
    mix_g = acc_g ^ {COMP_W{frame_inv}};
    mix_b = acc_b ^ {COMP_W{frame_inv}};
    if (s1_hb || s1_vb) begin
      mix_r = '0;
      mix_g = '0;
      mix_b = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      {r_out, g_out, b_out} <= '0;
      {hsync_out, vsync_out, hblank_out, vblank_out} <= '0;
    end else if (ce_pix) begin
      {r_out, g_out, b_out} <= {mix_r, mix_g, mix_b};
      {hsync_out, vsync_out, hblank_out, vblank_out} <= {s1_hs, s1_vs, s1_hb, s1_vb};
    end
  end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed-vector bench for video_layer_mixer (4 layers, 4-bit colour, 2-frame blink).
module tb_video_layer_mixer;

  localparam int NL = 4;
  localparam int CW = 4;
  localparam int BF = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b0;
  logic          color_mode = 1'b0;
  logic [NL-1:0] layers_in = '0;
  logic          inv_in = 1'b0;
  logic [NL-1:0] blink_en = '0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
  logic          pal_we = 1'b0;
  logic [2:0]    pal_addr = '0;
  logic [11:0]   pal_data = '0;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hsync_out, vsync_out, hblank_out, vblank_out, frame_inv;
  logic [11:0]   rgb;

  int n_vec = 0;
  int n_err = 0;

  assign rgb = {r_out, g_out, b_out};

  always #5 clk_sys = ~clk_sys;

  video_layer_mixer #(.NUM_LAYERS(NL), .COMP_W(CW), .BLINK_FRAMES(BF)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .color_mode (color_mode),
    .layers_in  (layers_in),
    .inv_in     (inv_in),
    .blink_en   (blink_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out),
    .frame_inv  (frame_inv)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One pixel beat followed by `gap` stalled cycles.
  task automatic beat(input int gap);
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce_pix = 1'b1;
    hsync_in = 1'b1;
    hblank_in = 1'b1;
    layers_in = 4'b1111;
    repeat (3) tick();
    n_vec++;
    if ({rgb, hsync_out, vsync_out, hblank_out, vblank_out, frame_inv} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rgb=%h sync=%b%b%b%b inv=%b, want all 0",
               rgb, hsync_out, vsync_out, hblank_out, vblank_out, frame_inv);
    end
    ce_pix = 1'b0;
    hsync_in = 1'b0;
    hblank_in = 1'b0;
    layers_in = 4'b0001;
    reset_n = 1'b1;
    tick();
    beat(3);
    n_vec++;
    if (rgb !== 12'h000) begin
      n_err++;
      $display("FAIL latency_one_beat: got rgb=%h, want 000", rgb);
    end
    beat(3);
    n_vec++;
    if (rgb !== 12'h777) begin
      n_err++;
      $display("FAIL reset_default_palette: got rgb=%h, want 777", rgb);
    end
    n_vec++;
    if (frame_inv !== 1'b0) begin
      n_err++;
      $display("FAIL reset_frame_inv: got %b, want 0", frame_inv);
    end
  endtask

  task automatic test_saturation();
    layers_in = 4'b0111;
    beat(0); beat(0);
    n_vec++;
    if (rgb !== 12'hFFF) begin
      n_err++;
      $display("FAIL sat_three_layers: got rgb=%h, want fff", rgb);
    end
    pal_we = 1'b1;
    pal_addr = 3'b101;
    pal_data = 12'h0FF;
    tick();
    pal_we = 1'b0;
    color_mode = 1'b1;
    layers_in = 4'b0011;
    beat(0); beat(0);
    n_vec++;
    if (rgb !== 12'h7FF) begin
      n_err++;
      $display("FAIL bank1_colour_sat: got rgb=%h, want 7ff", rgb);
    end
    color_mode = 1'b0;
    beat(0); beat(0);
    n_vec++;
    if (rgb !== 12'hEEE) begin
      n_err++;
      $display("FAIL bank0_untouched: got rgb=%h, want eee", rgb);
    end
  endtask

  task automatic test_timing();
    layers_in = 4'b0001;
    hsync_in = 1'b1;
    hblank_in = 1'b1;
    beat(1);
    hsync_in = 1'b0;
    hblank_in = 1'b0;
    vblank_in = 1'b1;
    beat(1);
    n_vec++;
    if ({hsync_out, hblank_out, vblank_out, rgb} !== {3'b110, 12'h000}) begin
      n_err++;
      $display("FAIL timing_hblank: got hs/hb/vb=%b%b%b rgb=%h, want 110 000",
               hsync_out, hblank_out, vblank_out, rgb);
    end
    vblank_in = 1'b0;
    beat(1);
    n_vec++;
    if ({hsync_out, hblank_out, vblank_out, rgb} !== {3'b001, 12'h000}) begin
      n_err++;
      $display("FAIL timing_vblank: got hs/hb/vb=%b%b%b rgb=%h, want 001 000",
               hsync_out, hblank_out, vblank_out, rgb);
    end
    beat(1);
    n_vec++;
    if ({hsync_out, hblank_out, vblank_out, rgb} !== {3'b000, 12'h777}) begin
      n_err++;
      $display("FAIL timing_clear: got hs/hb/vb=%b%b%b rgb=%h, want 000 777",
               hsync_out, hblank_out, vblank_out, rgb);
    end
  endtask

  task automatic test_inversion();
    layers_in = 4'b0000;
    inv_in = 1'b1;
    beat(1);
    inv_in = 1'b0;
    beat(1); beat(1);
    n_vec++;
    if ({frame_inv, rgb} !== {1'b0, 12'h000}) begin
      n_err++;
      $display("FAIL inv_pending: got inv=%b rgb=%h, want 0 000", frame_inv, rgb);
    end
    vsync_in = 1'b1;
    beat(1);
    n_vec++;
    if (frame_inv !== 1'b1) begin
      n_err++;
      $display("FAIL inv_latched_on_edge: got %b, want 1", frame_inv);
    end
    vsync_in = 1'b0;
    beat(1);
    n_vec++;
    if (vsync_out !== 1'b1) begin
      n_err++;
      $display("FAIL vsync_latency: got %b, want 1", vsync_out);
    end
    beat(1);
    n_vec++;
    if ({vsync_out, rgb} !== {1'b0, 12'hFFF}) begin
      n_err++;
      $display("FAIL inv_black_to_white: got vs=%b rgb=%h, want 0 fff", vsync_out, rgb);
    end
    hblank_in = 1'b1;
    beat(1); beat(1);
    n_vec++;
    if ({hblank_out, rgb} !== {1'b1, 12'h000}) begin
      n_err++;
      $display("FAIL blank_beats_inv: got hb=%b rgb=%h, want 1 000", hblank_out, rgb);
    end
    hblank_in = 1'b0;
    repeat (3) beat(1);
    n_vec++;
    if (frame_inv !== 1'b1) begin
      n_err++;
      $display("FAIL inv_held_whole_frame: got %b, want 1", frame_inv);
    end
    vsync_in = 1'b1;
    beat(1);
    vsync_in = 1'b0;
    n_vec++;
    if (frame_inv !== 1'b0) begin
      n_err++;
      $display("FAIL inv_one_frame_only: got %b, want 0", frame_inv);
    end
    beat(1); beat(1);
    n_vec++;
    if (rgb !== 12'h000) begin
      n_err++;
      $display("FAIL inv_released_output: got rgb=%h, want 000", rgb);
    end
  endtask

  task automatic test_edge_inv();
    beat(1);
    vsync_in = 1'b1;
    inv_in = 1'b1;
    beat(1);
    inv_in = 1'b0;
    n_vec++;
    if (frame_inv !== 1'b1) begin
      n_err++;
      $display("FAIL edge_beat_inv: got %b, want 1", frame_inv);
    end
    repeat (3) beat(1);
    n_vec++;
    if (frame_inv !== 1'b1) begin
      n_err++;
      $display("FAIL vsync_held_no_edge: got %b, want 1", frame_inv);
    end
    vsync_in = 1'b0;
    beat(1);
    vsync_in = 1'b1;
    beat(1);
    vsync_in = 1'b0;
    n_vec++;
    if (frame_inv !== 1'b0) begin
      n_err++;
      $display("FAIL cur_inv_cleared_on_edge: got %b, want 0", frame_inv);
    end
    beat(1);
    inv_in = 1'b1;
    beat(1);
    inv_in = 1'b0;
    vsync_in = 1'b1;
    tick(); tick();
    vsync_in = 1'b0;
    tick();
    beat(1);
    n_vec++;
    if (frame_inv !== 1'b0) begin
      n_err++;
      $display("FAIL stalled_vsync_ignored: got %b, want 0", frame_inv);
    end
    vsync_in = 1'b1;
    beat(1);
    vsync_in = 1'b0;
    n_vec++;
    if (frame_inv !== 1'b1) begin
      n_err++;
      $display("FAIL pending_inv_applied: got %b, want 1", frame_inv);
    end
  endtask

  task automatic test_reset_midframe();
    layers_in = 4'b0001;
    color_mode = 1'b0;
    beat(1); beat(1);
    n_vec++;
    if (rgb !== 12'h888) begin
      n_err++;
      $display("FAIL pre_reset_inverted: got rgb=%h, want 888", rgb);
    end
    reset_n = 1'b0;
    #2;
    n_vec++;
    if ({rgb, frame_inv} !== 13'h0) begin
      n_err++;
      $display("FAIL async_reset_midframe: got rgb=%h inv=%b, want 000 0", rgb, frame_inv);
    end
    tick();
    reset_n = 1'b1;
    tick();
    color_mode = 1'b1;
    layers_in = 4'b0011;
    beat(1); beat(1);
    n_vec++;
    if ({frame_inv, rgb} !== {1'b0, 12'hEEE}) begin
      n_err++;
      $display("FAIL palette_restored: got inv=%b rgb=%h, want 0 eee", frame_inv, rgb);
    end
    color_mode = 1'b0;
  endtask

  task automatic test_blink();
    logic [11:0] exp_rgb [4];
    exp_rgb[0] = 12'h777;
    exp_rgb[1] = 12'h000;
    exp_rgb[2] = 12'h000;
    exp_rgb[3] = 12'h777;
    blink_en = 4'b0001;
    layers_in = 4'b0001;
    beat(1); beat(1);
    n_vec++;
    if (rgb !== 12'h777) begin
      n_err++;
      $display("FAIL blink_first_frame: got rgb=%h, want 777", rgb);
    end
    for (int i = 0; i < 4; i++) begin
      vsync_in = 1'b1;
      beat(1);
      vsync_in = 1'b0;
      beat(1); beat(1);
      n_vec++;
      if (rgb !== exp_rgb[i]) begin
        n_err++;
        $display("FAIL blink_frame_%0d: got rgb=%h, want %h", i + 1, rgb, exp_rgb[i]);
      end
      if (i == 1) begin
        layers_in = 4'b0011;
        beat(1); beat(1);
        n_vec++;
        if (rgb !== 12'h777) begin
          n_err++;
          $display("FAIL blink_other_layer: got rgb=%h, want 777", rgb);
        end
        layers_in = 4'b0001;
      end
    end
    blink_en = 4'b0000;
  endtask

  task automatic test_collision_stall();
    layers_in = 4'b0001;
    pal_we = 1'b1;
    pal_addr = 3'b000;
    pal_data = 12'h123;
    ce_pix = 1'b1;
    tick();
    pal_we = 1'b0;
    ce_pix = 1'b0;
    beat(1);
    n_vec++;
    if (rgb !== 12'h777) begin
      n_err++;
      $display("FAIL collision_old_value: got rgb=%h, want 777", rgb);
    end
    beat(1);
    n_vec++;
    if (rgb !== 12'h123) begin
      n_err++;
      $display("FAIL collision_new_value: got rgb=%h, want 123", rgb);
    end
    layers_in = 4'b1111;
    hsync_in = 1'b1;
    hblank_in = 1'b1;
    vblank_in = 1'b1;
    vsync_in = 1'b1;
    inv_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if ({rgb, hsync_out, vsync_out, hblank_out, vblank_out, frame_inv} !== {12'h123, 5'b00000}) begin
        n_err++;
        $display("FAIL stall_hold_cycle_%0d: got rgb=%h sync=%b%b%b%b inv=%b, want 123 0000 0",
                 c, rgb, hsync_out, vsync_out, hblank_out, vblank_out, frame_inv);
      end
    end
    layers_in = 4'b0001;
    {hsync_in, hblank_in, vblank_in, vsync_in, inv_in} = '0;
    beat(1); beat(1);
    n_vec++;
    if ({frame_inv, rgb} !== {1'b0, 12'h123}) begin
      n_err++;
      $display("FAIL stall_resume: got inv=%b rgb=%h, want 0 123", frame_inv, rgb);
    end
  endtask

  task automatic test_back_to_back();
    logic [NL-1:0] pix [6];
    logic [11:0]   exp_rgb [5];
    pix[0] = 4'b0001; exp_rgb[0] = 12'h123;
    pix[1] = 4'b0010; exp_rgb[1] = 12'h777;
    pix[2] = 4'b0011; exp_rgb[2] = 12'h89A;
    pix[3] = 4'b0000; exp_rgb[3] = 12'h000;
    pix[4] = 4'b0111; exp_rgb[4] = 12'hFFF;
    pix[5] = 4'b0000;
    ce_pix = 1'b1;
    for (int i = 0; i < 6; i++) begin
      layers_in = pix[i];
      tick();
      if (i >= 1) begin
        n_vec++;
        if (rgb !== exp_rgb[i-1]) begin
          n_err++;
          $display("FAIL back_to_back_px%0d: got rgb=%h, want %h", i - 1, rgb, exp_rgb[i-1]);
        end
      end
    end
    ce_pix = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_timing();
    test_inversion();
    test_edge_inv();
    test_reset_midframe();
    test_blink();
    test_collision_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_layer_mixer.md
Name: video_layer_mixer

Overview:
- Parametrised successor to the fixed 4-bit monochrome/colour video mix used by the discrete-logic arcade cores.
- Takes NUM_LAYERS 1-bit video layers and looks up a per-layer RGB weight from one of two programmable palette banks (mono or colour).
- Saturating-sums the weights, applies layer blink and a frame-latched screen inversion, and forces black during blanking.
- Sits between the game core and arcade_video. It outputs COMP_W-bit RGB plus sync and blank signals delayed to match the pixel data.

Parameters:
NUM_LAYERS, 4, number of 1-bit video layers (2..8)
COMP_W, 4, bits per output colour component (4..8)
BLINK_FRAMES, 16, frames per blink half-period (≥1)

Ports:
clk_sys in 1 pixel-domain clock
reset_n in 1 asynchronous active-low reset
ce_pix in 1 pixel enable; pipeline and frame logic advance only when high
color_mode in 1 0 = palette bank 0 (mono), 1 = bank 1 (colour)
layers_in in NUM_LAYERS layer-active bits, one per layer
inv_in in 1 per-pixel request to invert the next frame
blink_en in NUM_LAYERS per-layer blink enable
hsync_in, vsync_in, hblank_in, vblank_in in 1 each, active-high timing from the core
pal_we in 1 palette write strobe
pal_addr in $clog2(NUM_LAYERS)+1 {bank, layer}
pal_data in 3*COMP_W {r, g, b} weight
r_out, g_out, b_out out COMP_W mixed colour
hsync_out, vsync_out, hblank_out, vblank_out out 1 each, timing delayed to match colour
frame_inv out 1 inversion state currently applied

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - cur_inv, frame_inv, blink counter and blink_phase are 0.
  - Every palette entry in both banks is H,H,H, where H = 2^(COMP_W-1)-1 (7 for COMP_W=4).
- Palette writes:
  - Accepted on any clk_sys edge with pal_we=1, independent of ce_pix.
  - The new value is visible to a lookup from the next cycle. A lookup in the same cycle uses the old value.
  - A write to layer index ≥ NUM_LAYERS is ignored.
- Pipeline: 2 stages, advancing on ce_pix only.
  - Latency is exactly 2 ce_pix beats for colour and for all four timing outputs.
  - When ce_pix=0, all registers hold.
- Stage 1:
  - Effective layer bit: eff[i] = layers_in[i] & ~(blink_en[i] & blink_phase).
  - Weight for each layer: eff[i] ? pal[color_mode][i] : 0.
  - Register the per-layer weights and the timing signals.
- Stage 2:
  - Each component is the sum of all layer weights, computed at width COMP_W+$clog2(NUM_LAYERS).
  - If the sum exceeds 2^COMP_W-1, the component is 2^COMP_W-1 (saturate, never wrap).
  - The result is XORed with {COMP_W{frame_inv}}.
  - If hblank or vblank of the same stage is set, the output is 0 after inversion, so blank is always black.
- Inversion:
  - On each ce_pix beat, cur_inv <= cur_inv | inv_in.
  - Rising edge of vsync_in: the previous vsync sample is registered on ce_pix. On the edge beat, frame_inv <= cur_inv | inv_in and cur_inv <= 0.
  - frame_inv is therefore constant for a whole frame and reflects requests from the previous frame, including the edge beat.
- Blink:
  - The frame counter (0..BLINK_FRAMES-1) increments on each vsync rising-edge beat.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - BLINK_FRAMES=1 toggles every frame.
- color_mode and blink_en may change at any time; they are sampled at stage 1.
- vsync held high is not an edge. A vsync rising edge while ce_pix=0 is detected on the next ce_pix beat only if vsync is still high.
- Reset mid-frame clears the pipeline contents and inversion state. Palette contents return to their defaults.

Decomposition:
- Package video_mix_pkg holds:
  - palette entry struct {r,g,b} parameterised via localparam widths;
  - function sat_add;
  - localparam PAL_DEFAULT.
- Sub-module vmix_frame_ctl holds the vsync edge detect, inversion accumulator and blink counter/phase. It outputs frame_inv and blink_phase.
- The palette RAM and the 2-stage datapath stay in the top module.

Test Plan:
- Reset defaults: NUM_LAYERS=4, COMP_W=4, reset, layers_in=4'b0001 with no blank, ce_pix every 4th cycle → after 2 ce_pix beats r/g/b=7,7,7 and frame_inv=0.
- Saturation: layers 0,1,2 active at default palette → 21 saturates to 15,15,15. Program bank1 layer1={0,15,15}, color_mode=1, layers=4'b0011 → 7,15,15.
- Inversion latch: pulse inv_in for 1 beat mid-frame → frame_inv stays 0 until the next vsync rising edge, then 1 for exactly one frame. Output with no layers and no blank = 15,15,15; blank still gives 0.
- Edge-beat inv: inv_in high only on the vsync rising-edge beat → frame_inv=1 in the following frame; cur_inv is cleared.
- Blink: BLINK_FRAMES=2, blink_en[0]=1, layer0 always on → output 7,7,7 for 2 frames, then 0,0,0 for 2 frames, repeating. Non-blinking layer1 is unaffected.
- Palette write collision and ce_pix stall: write during a beat → old value that beat, new value from the next cycle. Hold ce_pix=0 for 10 cycles → outputs and syncs frozen.
